// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter.
// Consumed by mem_arb_prio and mem_arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

    typedef enum logic {PORT_IF, PORT_D} arb_port_t;

    localparam logic [3:0] FETCH_BE = 4'hF;

endpackage

// File: rtl/mem_arb_prio.sv
// Winner selection between fetch and data ports.
// MEM_ARB_RR_EN selects round-robin instead of data priority + anti-starvation.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      i_if_req,
    input  logic      i_d_req,
    input  logic      i_grant_fire,
    output arb_port_t o_winner
);

    logic w_both;
    assign w_both = i_if_req && i_d_req;

`ifdef MEM_ARB_RR_EN
    arb_port_t r_last;

    always_comb begin
        o_winner = PORT_IF;
        if (w_both)
            o_winner = (r_last == PORT_IF) ? PORT_D : PORT_IF;
        else if (i_d_req)
            o_winner = PORT_D;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_last <= PORT_IF;
        else if (i_grant_fire)
            r_last <= o_winner;
    end
`else
    logic [3:0] r_starve_cnt;
    logic       w_starved;

    assign w_starved = (r_starve_cnt == 4'(STARVE_MAX));

    always_comb begin
        o_winner = PORT_IF;
        if (w_both)
            o_winner = w_starved ? PORT_IF : PORT_D;
        else if (i_d_req)
            o_winner = PORT_D;
    end

    // Counts data grants that left a fetch waiting; saturates at STARVE_MAX.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_starve_cnt <= 4'd0;
        else if (i_grant_fire) begin
            if (o_winner == PORT_IF || !i_if_req)
                r_starve_cnt <= 4'd0;
            else if (!w_starved)
                r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and load/store onto one single-port RAM.
// Optional MEM_ARB_RR_EN: round-robin arbitration on contention.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        m_en,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_be,
    input  logic [31:0] m_rdata,
    output logic        stall
);

    arb_state_t r_state;
    arb_port_t  r_port;
    logic [2:0] r_lat_cnt;
    arb_port_t  w_winner;
    logic       w_grant;

    assign w_grant = (r_state == IDLE) && (if_req || d_req);
    assign stall   = (if_req & ~if_valid) | (d_req & ~d_valid);

    mem_arb_prio #(
        .STARVE_MAX(STARVE_MAX)
    ) u_prio (
        .clk         (clk),
        .reset       (reset),
        .i_if_req    (if_req),
        .i_d_req     (d_req),
        .i_grant_fire(w_grant),
        .o_winner    (w_winner)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_port    <= PORT_IF;
            r_lat_cnt <= 3'd0;
            m_en      <= 1'b0;
            m_we      <= 1'b0;
            m_addr    <= 32'd0;
            m_wdata   <= 32'd0;
            m_be      <= 4'd0;
            if_valid  <= 1'b0;
            d_valid   <= 1'b0;
            if_rdata  <= 32'd0;
            d_rdata   <= 32'd0;
        end else begin
            m_en     <= 1'b0;
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_state <= ISSUE;
                        r_port  <= w_winner;
                        m_en    <= 1'b1;
                        if (w_winner == PORT_D) begin
                            m_we    <= d_we;
                            m_addr  <= {d_addr[31:2], 2'b00};
                            m_wdata <= d_wdata;
                            m_be    <= d_be;
                        end else begin
                            m_we   <= 1'b0;
                            m_addr <= {if_addr[31:2], 2'b00};
                            m_be   <= FETCH_BE;
                        end
                    end
                end
                ISSUE: begin
                    r_state   <= WAIT;
                    r_lat_cnt <= 3'd1;
                end
                WAIT: begin
                    if (r_lat_cnt == 3'(MEM_LAT)) begin
                        r_state <= RESP;
                        if (r_port == PORT_IF) begin
                            if_rdata <= m_rdata;
                            if_valid <= 1'b1;
                        end else begin
                            if (!m_we)
                                d_rdata <= m_rdata;
                            d_valid <= 1'b1;
                        end
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 3'd1;
                    end
                end
                RESP: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LAT=1/STARVE_MAX=2,
// one at MEM_LAT=3 for the reset-abort scenario.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic [3:0]  d_be = 4'd0;

    logic [31:0] a_if_rdata, a_d_rdata, a_m_addr, a_m_wdata, a_m_rdata;
    logic        a_if_valid, a_d_valid, a_m_en, a_m_we, a_stall;
    logic [3:0]  a_m_be;
    logic [31:0] b_if_rdata, b_d_rdata, b_m_addr, b_m_wdata, b_m_rdata;
    logic        b_if_valid, b_d_valid, b_m_en, b_m_we, b_stall;
    logic [3:0]  b_m_be;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        if (a == 32'h10)
            return 32'h0051_0093;
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory models: data valid exactly MEM_LAT cycles after the m_en cycle.
    logic [2:0] a_cnt = 3'd0;
    logic [2:0] b_cnt = 3'd0;
    always @(posedge clk) begin
        if (a_m_en) a_cnt <= 3'd1;
        else if (a_cnt != 3'd0 && a_cnt != 3'd7) a_cnt <= a_cnt + 3'd1;
        if (b_m_en) b_cnt <= 3'd1;
        else if (b_cnt != 3'd0 && b_cnt != 3'd7) b_cnt <= b_cnt + 3'd1;
    end
    assign a_m_rdata = (a_cnt == 3'd1) ? word(a_m_addr) : 32'hBAD0_BAD0;
    assign b_m_rdata = (b_cnt == 3'd3) ? word(b_m_addr) : 32'hBAD0_BAD0;

    mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(2)) dut_a (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(a_if_rdata), .if_valid(a_if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(a_d_rdata), .d_valid(a_d_valid),
        .m_en(a_m_en), .m_we(a_m_we), .m_addr(a_m_addr),
        .m_wdata(a_m_wdata), .m_be(a_m_be), .m_rdata(a_m_rdata),
        .stall(a_stall)
    );

    mem_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) dut_b (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(b_if_rdata), .if_valid(b_if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(b_d_rdata), .d_valid(b_d_valid),
        .m_en(b_m_en), .m_we(b_m_we), .m_addr(b_m_addr),
        .m_wdata(b_m_wdata), .m_be(b_m_be), .m_rdata(b_m_rdata),
        .stall(b_stall)
    );

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (a_m_en !== 1'b0) begin bad++; $display("FAIL rst_m_en got=%b exp=0", a_m_en); end
        total++; if (a_m_we !== 1'b0) begin bad++; $display("FAIL rst_m_we got=%b exp=0", a_m_we); end
        total++; if (a_m_addr !== 32'd0) begin bad++; $display("FAIL rst_m_addr got=%h exp=0", a_m_addr); end
        total++; if (a_m_wdata !== 32'd0) begin bad++; $display("FAIL rst_m_wdata got=%h exp=0", a_m_wdata); end
        total++; if (a_m_be !== 4'd0) begin bad++; $display("FAIL rst_m_be got=%h exp=0", a_m_be); end
        total++; if ({a_if_valid, a_d_valid} !== 2'b00) begin bad++; $display("FAIL rst_valid got=%b%b exp=00", a_if_valid, a_d_valid); end
        total++; if (a_if_rdata !== 32'd0 || a_d_rdata !== 32'd0) begin bad++; $display("FAIL rst_rdata got=%h/%h exp=0/0", a_if_rdata, a_d_rdata); end
        total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", a_stall); end
        @(posedge clk); #1 reset = 1'b1;
    endtask

    task automatic test_fetch();
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h10;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            total++; if (a_m_en !== (c == 1)) begin bad++; $display("FAIL fetch_m_en c=%0d got=%b exp=%b", c, a_m_en, c == 1); end
            total++; if (a_if_valid !== (c == 3)) begin bad++; $display("FAIL fetch_valid c=%0d got=%b exp=%b", c, a_if_valid, c == 3); end
            total++; if (a_stall !== (c <= 2)) begin bad++; $display("FAIL fetch_stall c=%0d got=%b exp=%b", c, a_stall, c <= 2); end
            if (c == 1) begin
                total++; if (a_m_addr !== 32'h10 || a_m_be !== 4'hF || a_m_we !== 1'b0) begin bad++; $display("FAIL fetch_mem c=1 got=%h/%h/%b exp=10/f/0", a_m_addr, a_m_be, a_m_we); end
            end
            if (c == 3) begin
                total++; if (a_if_rdata !== 32'h0051_0093) begin bad++; $display("FAIL fetch_rdata got=%h exp=00510093", a_if_rdata); end
            end
            @(posedge clk); #1;
            if (c == 3) if_req = 1'b0;
        end
    endtask

    task automatic test_contention();
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h203;
        if_req = 1'b1; if_addr = 32'h40;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            total++; if (a_m_en !== (c == 1 || c == 5)) begin bad++; $display("FAIL cont_m_en c=%0d got=%b exp=%b", c, a_m_en, c == 1 || c == 5); end
            total++; if (a_d_valid !== (c == 3)) begin bad++; $display("FAIL cont_d_valid c=%0d got=%b exp=%b", c, a_d_valid, c == 3); end
            total++; if (a_if_valid !== (c == 7)) begin bad++; $display("FAIL cont_if_valid c=%0d got=%b exp=%b", c, a_if_valid, c == 7); end
            total++; if (a_stall !== (c < 7)) begin bad++; $display("FAIL cont_stall c=%0d got=%b exp=%b", c, a_stall, c < 7); end
            if (c == 1) begin
                total++; if (a_m_addr !== 32'h200) begin bad++; $display("FAIL cont_d_addr got=%h exp=200", a_m_addr); end
            end
            if (c == 3) begin
                total++; if (a_d_rdata !== word(32'h200)) begin bad++; $display("FAIL cont_d_rdata got=%h exp=%h", a_d_rdata, word(32'h200)); end
            end
            if (c == 5) begin
                total++; if (a_m_addr !== 32'h40) begin bad++; $display("FAIL cont_if_addr got=%h exp=40", a_m_addr); end
            end
            if (c == 7) begin
                total++; if (a_if_rdata !== word(32'h40)) begin bad++; $display("FAIL cont_if_rdata got=%h exp=%h", a_if_rdata, word(32'h40)); end
            end
            @(posedge clk); #1;
            if (c == 3) d_req = 1'b0;
            if (c == 7) if_req = 1'b0;
        end
    endtask

    task automatic test_held();
        logic [5:0] exp_d;
        logic [5:0] got_d;
        int n;
`ifdef MEM_ARB_RR_EN
        exp_d = 6'b101010;
`else
        exp_d = 6'b110110;
`endif
        got_d = 6'd0;
        n = 0;
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        if_req = 1'b1; if_addr = 32'h80;
        for (int c = 0; c <= 23; c++) begin
            @(negedge clk);
            if (a_m_en === 1'b1) begin
                if (n < 6) got_d[5 - n] = (a_m_addr == 32'h100);
                n++;
            end
            @(posedge clk); #1;
            if (c == 23) begin
                d_req = 1'b0; if_req = 1'b0;
            end
        end
        total++; if (n != 6) begin bad++; $display("FAIL held_count got=%0d exp=6", n); end
        total++; if (got_d !== exp_d) begin bad++; $display("FAIL held_order got=%b exp=%b (1=D)", got_d, exp_d); end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_store();
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h307;
        d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            total++; if (a_d_valid !== (c == 3)) begin bad++; $display("FAIL st_valid c=%0d got=%b exp=%b", c, a_d_valid, c == 3); end
            if (c == 1) begin
                total++; if (a_m_en !== 1'b1 || a_m_we !== 1'b1) begin bad++; $display("FAIL st_en_we got=%b%b exp=11", a_m_en, a_m_we); end
                total++; if (a_m_be !== 4'b0011) begin bad++; $display("FAIL st_be got=%b exp=0011", a_m_be); end
                total++; if (a_m_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL st_wdata got=%h exp=deadbeef", a_m_wdata); end
                total++; if (a_m_addr !== 32'h304) begin bad++; $display("FAIL st_addr got=%h exp=304", a_m_addr); end
            end
            if (c == 3) begin
                total++; if (a_d_rdata !== word(32'h100)) begin bad++; $display("FAIL st_rdata got=%h exp=%h", a_d_rdata, word(32'h100)); end
            end
            @(posedge clk); #1;
            if (c == 3) begin
                d_req = 1'b0; d_we = 1'b0;
            end
        end
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_abort();
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h10;
        for (int c = 0; c <= 2; c++) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        if_req = 1'b0;
        #1;
        total++; if (b_m_addr !== 32'd0 || b_m_be !== 4'd0 || b_m_en !== 1'b0) begin bad++; $display("FAIL abort_clear got=%h/%h/%b exp=0/0/0", b_m_addr, b_m_be, b_m_en); end
        total++; if (b_if_valid !== 1'b0 || b_if_rdata !== 32'd0) begin bad++; $display("FAIL abort_if got=%b/%h exp=0/0", b_if_valid, b_if_rdata); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total++; if (b_if_valid !== 1'b0) begin bad++; $display("FAIL abort_novalid c=%0d got=%b exp=0", c, b_if_valid); end
        end
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h10;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            total++; if (b_m_en !== (c == 1)) begin bad++; $display("FAIL reissue_m_en c=%0d got=%b exp=%b", c, b_m_en, c == 1); end
            total++; if (b_if_valid !== (c == 5)) begin bad++; $display("FAIL reissue_valid c=%0d got=%b exp=%b", c, b_if_valid, c == 5); end
            if (c == 5) begin
                total++; if (b_if_rdata !== 32'h0051_0093) begin bad++; $display("FAIL reissue_rdata got=%h exp=00510093", b_if_rdata); end
            end
            @(posedge clk); #1;
            if (c == 5) if_req = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_contention();
        test_held();
        test_store();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port instruction/data memory between the core's fetch port and its load/store port, so the RV32I core can run from one unified RAM. Serialises the two requesters and pulses a one-cycle response per transaction. Holds `stall` while any request is outstanding, which freezes the PC register and register-file write. Sits between the core datapath and the memory macro.

## Interface
- `MEM_LAT`, 1: memory read latency in cycles from the `m_en` cycle to valid `m_rdata` (legal 1..4).
- `STARVE_MAX`, 4: consecutive contended data grants after which fetch wins once (legal 1..15).
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request, level, held until `if_valid`.
- `if_addr`  in  32  fetch byte address.
- `if_rdata`  out  32  fetched word, valid with `if_valid`.
- `if_valid`  out  1  one-cycle fetch completion pulse.
- `d_req`  in  1  data request, level, held until `d_valid`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  32  data byte address.
- `d_wdata`  in  32  store data.
- `d_be`  in  4  store byte enables.
- `d_rdata`  out  32  load word, valid with `d_valid`.
- `d_valid`  out  1  one-cycle data completion pulse, for loads and stores.
- `m_en`  out  1  memory access strobe, one cycle per transaction.
- `m_we`  out  1  memory write enable.
- `m_addr`  out  32  word address: winner's address with bits [1:0] forced to 0.
- `m_wdata`  out  32  write data.
- `m_be`  out  4  byte enables; `4'hF` for fetch.
- `m_rdata`  in  32  memory read data.
- `stall`  out  1  `(if_req & ~if_valid) | (d_req & ~d_valid)`, combinational.

## Operation
- FSM states:
  - IDLE: samples requests at each edge; if any request is high, latches the winner and goes to ISSUE; otherwise stays in IDLE.
  - ISSUE: `m_en`=1 for one cycle; next state is WAIT.
  - WAIT: lasts `MEM_LAT` cycles. On the last cycle, `m_rdata` is captured into the winner's rdata register; next state is RESP.
  - RESP: the winner's `*_valid`=1 for one cycle; requests are ignored; next state is IDLE.
- Latching at grant: the winner's address, write data, byte enables and `we` are latched into the `m_*` registers at the grant edge. Requester inputs may change freely afterwards.
- Fetch transactions: `m_we`=0, `m_be`=`4'hF`.
- Store transactions: `m_we`=1. `d_valid` still pulses in RESP, and `d_rdata` is left unchanged.
- Arbitration, no contention: the single requester wins.
- Arbitration, contention: data wins, except when `starve_cnt`==`STARVE_MAX`, in which case fetch wins.
- `starve_cnt` (4 bits):
  - increments on each data grant while `if_req`=1;
  - clears on any fetch grant;
  - clears on a data grant while `if_req`=0;
  - saturates at `STARVE_MAX`.
- Unused rdata registers hold their previous value.

## Timing
- Reset values: state IDLE; `m_en`, `m_we`, `if_valid`, `d_valid` = 0; `m_addr`, `m_wdata`, `if_rdata`, `d_rdata` = 0; `m_be` = 0; `starve_cnt` = 0.
- Request high in cycle 0: `m_en` in cycle 1, capture in cycle 1+`MEM_LAT`, `*_valid` in cycle 2+`MEM_LAT`, IDLE in cycle 3+`MEM_LAT`.
- Throughput: one transaction per `MEM_LAT`+3 cycles.
- The requester deasserts or changes its request at the edge ending its valid cycle. A request still high in the IDLE cycle is a new transaction.
- Simultaneous requests in IDLE: exactly one is granted. The loser stays pending, with `stall`=1, and is granted at the next IDLE.
- Reset asserted mid-transaction: all registers clear immediately, without waiting for the clock. The outstanding transaction is abandoned and no valid pulse is produced. The requester must reissue it.
- `stall` has no register delay and falls in the same cycle as the final valid.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - contended grants alternate via a 1-bit last-winner pointer; the winner is the port not granted last;
  - pointer resets to "fetch last", so data wins the first contention;
  - `starve_cnt` and `STARVE_MAX` are unused and not synthesised.
- `MEM_ARB_RR_EN` undefined: fixed data priority with the starvation counter, as described in Operation.

## Structure
- Package `mem_arb_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t`;
  - `typedef enum logic {PORT_IF, PORT_D} arb_port_t`;
  - localparam `FETCH_BE` = `4'hF`.
- Sub-module `mem_arb_prio` computes the winner from `if_req`, `d_req` and its internal state. Its internal state is `starve_cnt`, or the round-robin pointer when `MEM_ARB_RR_EN` is defined. It updates that state on a `grant_fire` input.
- `mem_arbiter` holds the FSM, latency counter and datapath registers.

## Test plan
- `MEM_LAT`=1. Fetch only, `if_addr`=0x0000_0010, memory returns 0x0051_0093 → `m_en` in cycle 1 with `m_addr`=0x10, `if_valid` in cycle 3 with `if_rdata`=0x0051_0093; `stall`=1 in cycles 0–2, 0 in cycle 3.
- Contention in the same cycle: load from 0x0000_0203 plus fetch → data is granted first with `m_addr`=0x200; fetch `m_en` occurs in cycle 5; `if_valid` pulses in cycle 7.
- Store with `d_be`=4'b0011, `d_wdata`=0xDEAD_BEEF → `m_we`=1, `m_be`=4'b0011 in the `m_en` cycle; `d_valid` pulses; `d_rdata` unchanged.
- Without the macro, `STARVE_MAX`=2, both requests held continuously → grant order D, D, IF, D, D, IF.
- With `MEM_ARB_RR_EN`, both requests held continuously → grant order D, IF, D, IF.
- `MEM_LAT`=3. Drop `reset` during WAIT → all outputs 0 immediately; no valid pulse; a reissued fetch completes 5 cycles after its request.
